// File: rtl/onehot_mux_decoded.sv
// Registered one-hot way multiplexer: selects one slice of a flattened multi-way bus with an
// AND-OR mux and reports the encoded way index, hit and multi-hot error flags.
module onehot_mux_decoded #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int NUM_WAY                  = 8,
    parameter int WAY_INDEX_WIDTH          = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic                                         valid_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_in,
    input  logic [NUM_WAY-1:0]                           sel_in,
    output logic                                         valid_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          way_flatted_out,
    output logic [WAY_INDEX_WIDTH-1:0]                   way_index_out,
    output logic                                         hit_out,
    output logic                                         sel_error_out
);

    logic [SINGLE_WAY_WIDTH_IN_BITS-1:0] way_data_next;
    logic [WAY_INDEX_WIDTH-1:0]          way_index_next;
    logic                                hit_next;
    logic                                sel_error_next;
    logic                                seen_one;

    // No priority chain: every set select bit ORs its way and index in, so a multi-hot select
    // yields the OR of the selected ways and a second set bit raises the error flag.
    always_comb begin
        way_data_next  = '0;
        way_index_next = '0;
        sel_error_next = 1'b0;
        seen_one       = 1'b0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (sel_in[i]) begin
                way_data_next  = way_data_next | way_flatted_in[i*SINGLE_WAY_WIDTH_IN_BITS +: SINGLE_WAY_WIDTH_IN_BITS];
                way_index_next = way_index_next | WAY_INDEX_WIDTH'(i);
                sel_error_next = sel_error_next | seen_one;
                seen_one       = 1'b1;
            end
        end
        hit_next = |sel_in;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            valid_out       <= 1'b0;
            way_flatted_out <= '0;
            way_index_out   <= '0;
            hit_out         <= 1'b0;
            sel_error_out   <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                way_flatted_out <= way_data_next;
                way_index_out   <= way_index_next;
                hit_out         <= hit_next;
                sel_error_out   <= sel_error_next;
            end
        end
    end

endmodule

// File: tb/tb_onehot_mux_decoded.sv
// Directed bench for onehot_mux_decoded: a per-cycle compare against a behavioural model plus
// hand-computed literal checks for the documented vectors.
module tb_onehot_mux_decoded;

    localparam int W  = 4;
    localparam int NW = 8;
    localparam int IW = 3;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic            valid_in;
    logic [W*NW-1:0] way_flatted_in;
    logic [NW-1:0]   sel_in;
    logic            valid_out;
    logic [W-1:0]    way_flatted_out;
    logic [IW-1:0]   way_index_out;
    logic            hit_out;
    logic            sel_error_out;

    int total_checks  = 0;
    int passed_checks = 0;

    logic          m_known = 1'b0;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [IW-1:0] m_index;
    logic          m_hit;
    logic          m_err;

    onehot_mux_decoded #(
        .SINGLE_WAY_WIDTH_IN_BITS(W),
        .NUM_WAY(NW),
        .WAY_INDEX_WIDTH(IW)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .valid_in(valid_in),
        .way_flatted_in(way_flatted_in),
        .sel_in(sel_in),
        .valid_out(valid_out),
        .way_flatted_out(way_flatted_out),
        .way_index_out(way_index_out),
        .hit_out(hit_out),
        .sel_error_out(sel_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Model: slices the bus into an array of ways and applies the select rules arithmetically.
    always @(posedge clk_in) begin
        logic [W-1:0] ways [NW];
        logic [W-1:0] d;
        int           idx;
        if (!reset_in) begin
            m_known <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            m_hit   <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_valid <= valid_in;
            if (valid_in) begin
                d   = '0;
                idx = 0;
                for (int i = 0; i < NW; i++) begin
                    ways[i] = W'(way_flatted_in >> (W * i));
                    if (sel_in[i]) begin
                        d   = d | ways[i];
                        idx = idx | i;
                    end
                end
                m_data  <= d;
                m_index <= IW'(idx);
                m_hit   <= (sel_in != '0);
                m_err   <= ($countones(sel_in) >= 2);
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_known) begin
            check_output("model_valid", 32'(valid_out), 32'(m_valid));
            check_output("model_data", 32'(way_flatted_out), 32'(m_data));
            check_output("model_index", 32'(way_index_out), 32'(m_index));
            check_output("model_hit", 32'(hit_out), 32'(m_hit));
            check_output("model_err", 32'(sel_error_out), 32'(m_err));
        end
    end

    task automatic apply_stimulus(input logic v, input logic [NW-1:0] s);
        @(negedge clk_in);
        #1;
        valid_in = v;
        sel_in   = s;
    endtask

    task automatic check_literal(input string tag, input logic v, input logic [W-1:0] d,
                                 input logic [IW-1:0] idx, input logic h, input logic e);
        @(posedge clk_in);
        #2;
        check_output({tag, "_valid"}, 32'(valid_out), 32'(v));
        check_output({tag, "_data"}, 32'(way_flatted_out), 32'(d));
        check_output({tag, "_index"}, 32'(way_index_out), 32'(idx));
        check_output({tag, "_hit"}, 32'(hit_out), 32'(h));
        check_output({tag, "_err"}, 32'(sel_error_out), 32'(e));
    endtask

    initial begin
        logic [W-1:0] sweep_exp [NW];
        sweep_exp = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha};

        reset_in       = 1'b0;
        valid_in       = 1'b1;
        way_flatted_in = 32'habcd_1234;
        sel_in         = 8'h20;
        @(posedge clk_in);
        check_literal("reset", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);

        @(negedge clk_in);
        reset_in = 1'b1;
        apply_stimulus(1'b1, 8'b0010_0000);
        check_literal("sel5", 1'b1, 4'hc, 3'd5, 1'b1, 1'b0);

        apply_stimulus(1'b0, 8'b0000_0001);
        check_literal("hold", 1'b0, 4'hc, 3'd5, 1'b1, 1'b0);

        for (int i = 0; i < NW; i++) begin
            apply_stimulus(1'b1, NW'(1) << i);
            check_literal($sformatf("sweep%0d", i), 1'b1, sweep_exp[i], IW'(i), 1'b1, 1'b0);
        end

        apply_stimulus(1'b1, 8'h00);
        check_literal("zerohot", 1'b1, 4'h0, 3'd0, 1'b0, 1'b0);

        apply_stimulus(1'b1, 8'b0000_0011);
        check_literal("multi01", 1'b1, 4'h7, 3'd1, 1'b1, 1'b1);

        apply_stimulus(1'b1, 8'b1010_0000);
        check_literal("multi57", 1'b1, 4'he, 3'd7, 1'b1, 1'b1);

        way_flatted_in = 32'h5a5a_c3c3;
        apply_stimulus(1'b1, 8'b0100_0000);
        check_literal("newbus6", 1'b1, 4'ha, 3'd6, 1'b1, 1'b0);

        apply_stimulus(1'b1, 8'b0010_0000);
        reset_in = 1'b0;
        check_literal("midreset", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0);

        @(negedge clk_in);
        reset_in = 1'b1;
        apply_stimulus(1'b1, 8'b0000_0100);
        check_literal("postreset", 1'b1, 4'h3, 3'd2, 1'b1, 1'b0);

        apply_stimulus(1'b0, 8'h00);
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
